keypad_scanner: RTL and testbench

Scans the 4x4 matrix keypad of the calculator, debounces key presses and emits a one-cycle strobe with a 4-bit key code. It sits directly upstream of the number-entry FSM, driving its key-strobe and key-nibble inputs. Operator keys use the same strobe and are flagged as non-digits for the operator path.

---
 rtl/keypad_scanner_if.sv | 22 ++
 rtl/keypad_scanner.sv | 230 +++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Key event bus from the keypad scanner to the number-entry / operator logic.
// The scanner drives through the master modport; consumers take the slave side.
interface keypad_scanner_if;
    logic       key_valid;     // one-cycle strobe: new key accepted
    logic [3:0] key_code;      // last accepted key, held until the next strobe
    logic       key_is_digit;  // key_code <= 9, valid with key_code
    logic       key_held;      // an accepted key has not yet been released

    modport master (
        output key_valid,
        output key_code,
        output key_is_digit,
        output key_held
    );

    modport slave (
        input key_valid,
        input key_code,
        input key_is_digit,
        input key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with per-key debounce and one-cycle key strobe.
// Drives one active-low column at a time, samples the synchronised rows once
// per column period, debounces press and release over DEBOUNCE_SCANS samples.
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-strobe a held key
// (first repeat after 64 pressed samples, then every 16 pressed samples).
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,  // clk cycles per column period, >= 4
    parameter int DEBOUNCE_SCANS = 8      // matching samples to accept, 2..255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       rows,
    output logic [3:0]       cols,
    keypad_scanner_if.master key_if
);

    localparam int               DIV_W      = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [7:0]       DEB_TARGET = 8'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       rows_meta_q, rows_meta_d;
    logic [3:0]       rs_q, rs_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_q, col_d;
    logic [3:0]       cols_q, cols_d;
    logic [1:0]       row_q, row_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       rel_q, rel_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_is_digit_q, key_is_digit_d;
    logic             key_held_q, key_held_d;

    logic             sample;
    logic             any_low;
    logic [1:0]       low_row;
    logic [3:0]       hit_code;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [6:0] REP_FIRST  = 7'd64;
    localparam logic [6:0] REP_REPEAT = 7'd80;  // REP_FIRST + 16
    logic [6:0] rep_q, rep_d;
    logic [6:0] rep_inc;
    assign rep_inc = rep_q + 7'd1;
`endif

    // Physical key position (row, column) to calculator key code.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'hE;  // '*'
            4'hD:    code = 4'h0;
            4'hE:    code = 4'hF;  // '#'
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign sample   = (div_q == DIV_LAST);
    assign any_low  = (rs_q != 4'hF);
    assign hit_code = key_map(row_q, col_q);

    // Lowest-index low row wins when several keys share the driven column.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        low_row = 2'd0;
        if (!rs_q[0])      low_row = 2'd0;
        else if (!rs_q[1]) low_row = 2'd1;
        else if (!rs_q[2]) low_row = 2'd2;
        else if (!rs_q[3]) low_row = 2'd3;
    end

    // Next-state and output logic of the scan / debounce / hold FSM.
    always_comb begin
        state_d        = state_q;
        rows_meta_d    = rows;
        rs_d           = rows_meta_q;
        div_d          = sample ? '0 : div_q + DIV_W'(1);
        col_d          = col_q;
        cols_d         = cols_q;
        row_d          = row_q;
        cnt_d          = cnt_q;
        rel_d          = rel_q;
        key_valid_d    = 1'b0;
        key_code_d     = key_code_q;
        key_is_digit_d = key_is_digit_q;
        key_held_d     = key_held_q;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d          = rep_q;
`endif

        if (sample) begin
            case (state_q)
                ST_SCAN: begin
                    if (any_low) begin
                        row_d   = low_row;
                        cnt_d   = 8'd1;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        col_d  = col_q + 2'd1;
                        cols_d = {cols_q[2:0], cols_q[3]};
                    end
                end

                ST_DEBOUNCE: begin
                    if (any_low && (low_row == row_q)) begin
                        if (cnt_q + 8'd1 == DEB_TARGET) begin
                            key_valid_d    = 1'b1;
                            key_code_d     = hit_code;
                            key_is_digit_d = (hit_code <= 4'd9);
                            key_held_d     = 1'b1;
                            cnt_d          = 8'd0;
                            rel_d          = 8'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_d          = 7'd0;
`endif
                            state_d        = ST_HELD;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        // Bounce or a different row: abandon this key and move on.
                        cnt_d   = 8'd0;
                        col_d   = col_q + 2'd1;
                        cols_d  = {cols_q[2:0], cols_q[3]};
                        state_d = ST_SCAN;
                    end
                end

                ST_HELD: begin
                    if (!any_low) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_d = 7'd0;
`endif
                        if (rel_q + 8'd1 == DEB_TARGET) begin
                            key_held_d = 1'b0;
                            rel_d      = 8'd0;
                            col_d      = col_q + 2'd1;
                            cols_d     = {cols_q[2:0], cols_q[3]};
                            state_d    = ST_SCAN;
                        end else begin
                            rel_d = rel_q + 8'd1;
                        end
                    end else begin
                        rel_d = 8'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (rep_inc == REP_FIRST) begin
                            key_valid_d = 1'b1;
                            rep_d       = rep_inc;
                        end else if (rep_inc == REP_REPEAT) begin
                            key_valid_d = 1'b1;
                            rep_d       = REP_FIRST;
                        end else begin
                            rep_d = rep_inc;
                        end
`endif
                    end
                end

                default: state_d = ST_SCAN;
            endcase
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q        <= ST_SCAN;
            rows_meta_q    <= 4'hF;
            rs_q           <= 4'hF;
            div_q          <= '0;
            col_q          <= 2'd0;
            cols_q         <= 4'b1110;
            row_q          <= 2'd0;
            cnt_q          <= 8'd0;
            rel_q          <= 8'd0;
            key_valid_q    <= 1'b0;
            key_code_q     <= 4'h0;
            key_is_digit_q <= 1'b0;
            key_held_q     <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q          <= 7'd0;
`endif
        end else begin
            state_q        <= state_d;
            rows_meta_q    <= rows_meta_d;
            rs_q           <= rs_d;
            div_q          <= div_d;
            col_q          <= col_d;
            cols_q         <= cols_d;
            row_q          <= row_d;
            cnt_q          <= cnt_d;
            rel_q          <= rel_d;
            key_valid_q    <= key_valid_d;
            key_code_q     <= key_code_d;
            key_is_digit_q <= key_is_digit_d;
            key_held_q     <= key_held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q          <= rep_d;
`endif
        end
    end

    assign cols                = cols_q;
    assign key_if.key_valid    = key_valid_q;
    assign key_if.key_code     = key_code_q;
    assign key_if.key_is_digit = key_is_digit_q;
    assign key_if.key_held     = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a switch-matrix keypad model drives
// the rows from the driven columns; every accepted strobe is logged and
// compared with the key code the calculator's key map assigns to the press.
// Define KEYPAD_AUTOREPEAT_EN to also exercise the auto-repeat behaviour.
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 3;
    localparam int RELEASE_MAX    = 19;

    // Key code for (row, column) as printed on the calculator keypad.
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    logic       clk;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       pressed [4][4];

    int n_assert = 0;
    int n_fail   = 0;

    // Strobe log, written only by the monitor.
    logic [3:0] cap_code  [$];
    logic       cap_digit [$];
    longint     cap_time  [$];
    longint     cyc        = 0;
    int         back2back  = 0;
    logic       prev_valid = 1'b0;
    int         rd_idx     = 0;

    keypad_scanner_if key_if ();

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rows   (rows),
        .cols   (cols),
        .key_if (key_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad switch matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && !cols[c]) rows[r] = 1'b0;
    end

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!reset && key_if.key_valid) begin
            if (prev_valid) back2back = back2back + 1;
            cap_code.push_back(key_if.key_code);
            cap_digit.push_back(key_if.key_is_digit);
            cap_time.push_back(cyc);
        end
        prev_valid = key_if.key_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                pressed[r][c] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cols"},  32'(cols),                4'b1110);
        check({tag, "_valid"}, 32'(key_if.key_valid),    0);
        check({tag, "_code"},  32'(key_if.key_code),     0);
        check({tag, "_digit"}, 32'(key_if.key_is_digit), 0);
        check({tag, "_held"},  32'(key_if.key_held),     0);
    endtask

    // Compare strobes logged since the last call against n_exp copies of code.
    task automatic expect_strobes(input string tag, input int n_exp, input logic [3:0] code);
        int n_got;
        n_got = cap_code.size() - rd_idx;
        check({tag, "_count"}, 32'(n_got), 32'(n_exp));
        for (int i = rd_idx; i < cap_code.size(); i++) begin
            check({tag, "_code"},  32'(cap_code[i]),  32'(code));
            check({tag, "_digit"}, 32'(cap_digit[i]), 32'(code <= 4'd9));
        end
        rd_idx = cap_code.size();
    endtask

    // Hold one key, release it, and verify the hold/release behaviour of key_held.
    task automatic press_release(input string tag, input int r, input int c, input int hold);
        int w;
        pressed[r][c] = 1'b1;
        tick(hold);
        check({tag, "_held_while_pressed"}, 32'(key_if.key_held), 1);
        pressed[r][c] = 1'b0;
        w = 0;
        while (key_if.key_held && w <= RELEASE_MAX + 5) begin
            tick(1);
            w++;
        end
        check({tag, "_release_in_time"}, 32'(w <= RELEASE_MAX), 1);
        tick(30);
        expect_strobes(tag, 1, KEY_MAP[r][c]);
    endtask

    initial begin
        int r;
        int c;
        int hold;
        release_all();
        reset = 1'b1;
        tick(3);
        check_reset_outputs("reset");

        // Idle scan: columns rotate every SCAN_DIV cycles, no strobe.
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            check("idle_cols", 32'(cols), 32'(~(4'b0001 << ((k / SCAN_DIV) % 4)) & 4'hF));
            check("idle_valid", 32'(key_if.key_valid), 0);
            tick(1);
        end

        // Clean presses of a digit and of operator keys.
        press_release("key5",    1, 1, 100);
        press_release("keyD",    3, 3, 80);
        press_release("keystar", 3, 0, 80);
        press_release("key0",    3, 1, 80);

        // Bouncing '7': toggle every 3 cycles for 30 cycles, then hold.
        for (int i = 0; i < 10; i++) begin
            pressed[2][0] = (i % 2 == 0);
            tick(3);
        end
        expect_strobes("bounce7_during", 0, 4'h7);
        press_release("bounce7", 2, 0, 80);

        // Two keys in different columns held together give one strobe.
        pressed[0][0] = 1'b1;
        tick(60);
        pressed[0][1] = 1'b1;
        tick(60);
        expect_strobes("two_keys", 1, 4'h1);
        release_all();
        tick(40);
        expect_strobes("two_keys_after_release", 0, 4'h1);
        press_release("key2_again", 0, 1, 80);

        // Reset in the middle of debouncing '4' (r1, c0).
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        pressed[1][0] = 1'b1;
        tick(9);
        reset = 1'b1;
        tick(1);
        check_reset_outputs("mid_debounce_reset");
        expect_strobes("mid_debounce_reset", 0, 4'h4);
        reset = 1'b0;
        tick(1);
        press_release("key4_after_reset", 1, 0, 60);

        // Randomised clean presses.
        for (int i = 0; i < 8; i++) begin
            r    = int'($urandom_range(0, 3));
            c    = int'($urandom_range(0, 3));
            hold = 60 + int'($urandom_range(0, 60));
            press_release("random_key", r, c, hold);
            tick(int'($urandom_range(0, 20)));
        end

`ifdef KEYPAD_AUTOREPEAT_EN
        // Auto-repeat on '3': first repeat 256 cycles after the strobe, then every 64.
        begin
            int base;
            pressed[0][2] = 1'b1;
            tick(400);
            release_all();
            tick(40);
            base = rd_idx;
            check("repeat_enough", 32'((cap_code.size() - base) >= 3), 1);
            if (cap_code.size() - base >= 3) begin
                check("repeat_first_gap",  32'(cap_time[base + 1] - cap_time[base]), 256);
                check("repeat_second_gap", 32'(cap_time[base + 2] - cap_time[base + 1]), 64);
            end
            expect_strobes("repeat_codes", cap_code.size() - base, 4'h3);
        end
`endif

        check("no_back_to_back_strobes", 32'(back2back), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
